// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction
// memory, buffers returned words with their PC and hands them to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   pc_mem_q   [QUEUE_DEPTH];
    logic [31:0]   data_mem_q [QUEUE_DEPTH];

    logic          pop;
    logic          accept;
    logic          rsp_take;
    logic          push;
    logic [CW:0]   credit_used;
    logic [31:0]   redir_aligned;
    logic [1:0]    unused_redir_lsb;

    assign unused_redir_lsb = redirect_pc[1:0];
    assign redir_aligned    = {redirect_pc[31:2], 2'b00};

    assign inst_valid = (count_q != '0) & !redirect_valid;
    assign inst_data  = data_mem_q[rd_ptr_q];
    assign inst_pc    = pc_mem_q[rd_ptr_q];
    assign pop        = inst_valid & inst_ready;

    // Requests in flight plus queued words must never exceed the queue
    // size, so every response is guaranteed a free slot on arrival.
    assign credit_used = (CW+1)'(outst_q) + (CW+1)'(count_q)
                       - (CW+1)'(pop);
    assign imem_req_valid = !rst & !redirect_valid
                          & (credit_used < (CW+1)'(QUEUE_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign accept         = imem_req_valid & imem_req_ready;

    // A response with nothing outstanding is a protocol error: ignore it.
    assign rsp_take = imem_rsp_valid & (outst_q != '0);
    assign push     = rsp_take & (drop_q == '0) & !redirect_valid;

    // Next-state: redirect flushes the queue and marks all in-flight
    // responses (minus one answered this cycle) as wrong-path.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (redirect_valid) begin
            fetch_pc_d = redir_aligned;
            rsp_pc_d   = redir_aligned;
            outst_d    = outst_q - CW'(rsp_take);
            drop_d     = outst_q - CW'(rsp_take);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            outst_d = outst_q + CW'(accept) - CW'(rsp_take);
            if (rsp_take && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // State and queue storage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
                data_mem_q[wr_ptr_q] <= imem_rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then randomized traffic, all
// checked against an in-order stream model and a memory model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    fetch_unit #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          pops = 0;
    int          lat = 1;
    bit          lat_rand = 0;
    logic [31:0] key = 32'h0;
    logic [31:0] exp_req = RST_PC;
    logic [31:0] exp_pc = RST_PC;

    bit          rst_v = 1;
    bit          req_rdy = 1;
    bit          ird = 1;
    bit          redir = 0;
    logic [31:0] redir_pc = 32'h0;

    logic        s_rv, s_iv, s_rspv;
    logic [31:0] s_addr, s_pc, s_data;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        logic acc, rspf, popf;
        int   d;
        @(negedge clk);
        rst            = rst_v;
        imem_req_ready = req_rdy;
        inst_ready     = ird;
        redirect_valid = redir;
        redirect_pc    = redir_pc;
        if (!rst_v && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend[0].addr ^ key;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        s_rv   = imem_req_valid;
        s_addr = imem_req_addr;
        s_iv   = inst_valid;
        s_pc   = inst_pc;
        s_data = inst_data;
        s_rspv = imem_rsp_valid;
        if (rst_v) begin
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        end else begin
            if (redir) begin
                check("redir_inst_valid", 32'(inst_valid), 32'd0);
                check("redir_req_valid", 32'(imem_req_valid), 32'd0);
            end
            if (imem_req_valid) begin
                check("req_addr", imem_req_addr, exp_req);
            end
            if (inst_valid && inst_ready) begin
                check("inst_pc", inst_pc, exp_pc);
                check("inst_data", inst_data, exp_pc ^ key);
            end
        end
        acc  = imem_req_valid & imem_req_ready & !rst_v;
        rspf = imem_rsp_valid;
        popf = inst_valid & inst_ready & !rst_v;
        @(posedge clk);
        if (rst_v) begin
            pend.delete();
            exp_req = RST_PC;
            exp_pc  = RST_PC;
        end else begin
            if (rspf) void'(pend.pop_front());
            if (acc) begin
                d = lat_rand ? int'($urandom_range(1, 4)) : lat;
                pend.push_back('{addr: s_addr, due: cyc + d});
                check("outstanding_limit", 32'(pend.size() > DEPTH), 32'd0);
            end
            if (redir) begin
                exp_req = {redir_pc[31:2], 2'b00};
                exp_pc  = {redir_pc[31:2], 2'b00};
            end else begin
                if (popf) begin
                    exp_pc = exp_pc + 32'd4;
                    pops++;
                end
                if (acc) exp_req = exp_req + 32'd4;
            end
        end
        cyc++;
    endtask

    initial begin
        int          n;
        logic [31:0] pc0;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;

        // reset values
        tick();
        tick();
        check("rst_req_valid_val", 32'(s_rv), 32'd0);
        check("rst_addr", s_addr, RST_PC);
        check("rst_inst_valid", 32'(s_iv), 32'd0);
        check("rst_inst_data", s_data, 32'h0);
        check("rst_inst_pc", s_pc, 32'h0);

        // streaming, one instruction per cycle from cycle 2
        rst_v = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 0) begin
                check("first_req_valid", 32'(s_rv), 32'd1);
                check("first_req_addr", s_addr, RST_PC);
            end
            if (k >= 2) begin
                check("stream_valid", 32'(s_iv), 32'd1);
                check("stream_pc", s_pc, RST_PC + 32'(4 * (k - 2)));
                check("stream_data", s_data, s_pc);
            end
        end

        // decoder stall: queue fills, requests stop, then resume
        ird = 0;
        for (int k = 0; k < 10; k++) tick();
        check("stall_req_valid", 32'(s_rv), 32'd0);
        check("stall_outstanding", 32'(pend.size()), 32'd0);
        check("stall_inst_valid", 32'(s_iv), 32'd1);
        ird = 1;
        pc0 = exp_pc;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("resume_valid", 32'(s_iv), 32'd1);
            check("resume_pc", s_pc, pc0 + 32'(4 * k));
        end

        // redirect with a slow response in flight
        lat = 3;
        for (int i = 0; i < 20 && pend.size() != 1; i++) tick();
        redir = 1; redir_pc = 32'h100;
        tick();
        redir = 0;
        n = 0;
        do begin tick(); n++; end while (!s_iv && n < 40);
        check("r100_valid", 32'(s_iv), 32'd1);
        check("r100_pc", s_pc, 32'h100);
        check("r100_latency", 32'(n >= 3), 32'd1);

        // redirect coinciding with a response, unaligned target
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            if (pend.size() > 0 && pend[0].due <= cyc) break;
            tick();
        end
        redir = 1; redir_pc = 32'h203;
        tick();
        check("r203_rsp_seen", 32'(s_rspv), 32'd1);
        check("r203_inst_valid", 32'(s_iv), 32'd0);
        redir = 0;
        tick();
        check("r203_req_valid", 32'(s_rv), 32'd1);
        check("r203_req_addr", s_addr, 32'h200);
        n = 0;
        while (!s_iv && n < 40) begin tick(); n++; end
        check("r203_first_valid", 32'(s_iv), 32'd1);
        check("r203_first_pc", s_pc, 32'h200);

        // memory back-pressure holds the address
        req_rdy = 0; redir = 1; redir_pc = 32'h40;
        tick();
        redir = 0;
        for (int k = 0; k < 6; k++) tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_valid", 32'(s_rv), 32'd1);
            check("hold_addr", s_addr, 32'h40);
        end
        req_rdy = 1;
        tick();
        check("hold_accept_addr", s_addr, 32'h40);
        tick();
        check("hold_next_valid", 32'(s_rv), 32'd1);
        check("hold_next_addr", s_addr, 32'h44);

        // reset mid-stream with a full queue
        ird = 0;
        for (int k = 0; k < 6; k++) tick();
        check("prerst_inst_valid", 32'(s_iv), 32'd1);
        rst_v = 1; key = 32'hC0DE_0000;
        tick();
        rst_v = 0; ird = 1;
        tick();
        check("postrst_inst_valid", 32'(s_iv), 32'd0);
        check("postrst_req_valid", 32'(s_rv), 32'd1);
        check("postrst_addr", s_addr, RST_PC);
        n = 0;
        while (!s_iv && n < 20) begin tick(); n++; end
        check("postrst_first_pc", s_pc, RST_PC);
        check("postrst_first_data", s_data, RST_PC ^ key);

        // randomized traffic
        lat_rand = 1;
        pops = 0;
        for (int k = 0; k < 3000; k++) begin
            req_rdy  = ($urandom % 10) < 7;
            ird      = ($urandom % 10) < 7;
            redir    = ($urandom % 100) < 4;
            redir_pc = $urandom;
            rst_v    = ($urandom % 500) == 0;
            tick();
        end
        rst_v = 0; redir = 0;
        check("random_progress", 32'(pops > 200), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
